// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four byte-stream requesters share one UART
// transmitter, holding ownership for a whole packet and releasing stalled owners.
module uart_tx_arbiter #(
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  input  logic        tx_ready,
  output logic        err_timeout,
  output logic [1:0]  err_id
);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT_DONE} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LIMIT  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                       TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t                   state_q, state_d;
  logic [1:0]               ptr_q, ptr_d;
  logic [3:0]               grant_q, grant_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_req_q;
  logic                     last_q, last_d;
  logic                     err_q, err_d;
  logic [1:0]               err_id_q, err_id_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  logic [1:0]               gidx;
  logic [1:0]               pick_idx;
  logic                     pick_found;
  logic [1:0]               cand;
  logic                     hs;
  logic [7:0]               sel_byte;
  logic                     sel_last;
  logic [TIMEOUT_WIDTH-1:0] cnt_inc;
  logic                     timeout_hit;

  function automatic logic [TIMEOUT_WIDTH-1:0] sat_inc(input logic [TIMEOUT_WIDTH-1:0] v);
    if (&v) return v;
    return v + TIMEOUT_WIDTH'(1);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign gidx        = onehot_idx(grant_q);
  assign hs          = (state_q == LOAD) && |(req_valid & grant_q);
  assign sel_byte    = req_data[{gidx, 3'b000} +: 8];
  assign sel_last    = req_last[gidx];
  assign cnt_inc     = sat_inc(cnt_q);
  assign timeout_hit = TIMEOUT_EN && (cnt_inc >= CNT_LIMIT);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    err_id_d  = err_id_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = 4'b0001 << pick_idx;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // A handshake in the same cycle as the limit wins over the timeout.
        if (hs) begin
          tx_data_d = sel_byte;
          last_d    = sel_last;
          state_d   = ISSUE;
        end else if (timeout_hit) begin
          cnt_d    = cnt_inc;
          grant_d  = 4'b0000;
          ptr_d    = gidx + 2'd1;
          err_d    = 1'b1;
          err_id_d = gidx;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ISSUE: begin
        if (tx_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          if (last_q) begin
            grant_d = 4'b0000;
            ptr_d   = gidx + 2'd1;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      grant_q   <= 4'b0000;
      tx_data_q <= 8'h00;
      tx_req_q  <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      err_id_q  <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= (state_d == ISSUE);
      last_q    <= last_d;
      err_q     <= err_d;
      err_id_q  <= err_id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready   = (state_q == LOAD) ? grant_q : 4'b0000;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign tx_data     = tx_data_q;
  assign tx_req      = tx_req_q;
  assign err_timeout = err_q;
  assign err_id      = err_id_q;

endmodule
